pipe_reg_chain: RTL and testbench

Parametrised multi-stage pipeline register chain with per-stage valid bits, stall and flush. It is the general form of the single-flop pipeline registers (plain, enable, enable+clear) used between processor stages. The block automatically propagates stalls upstream, inserts bubbles, drains under an output handshake and counts discarded instructions. It is used for the fetch→writeback register spine and for multi-cycle side paths.

---
 rtl/pipe_reg_chain.sv | 99 +++++++++
 tb/tb_pipe_reg_chain.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/pipe_reg_chain.sv
// rtl/pipe_reg_chain.sv - multi-stage valid-tagged pipeline register chain with stall, flush and bubbles
module pipe_reg_chain #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 3,
    parameter int CNTW   = 16
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           in_valid,
    input  logic [WIDTH-1:0]               in_data,
    output logic                           in_ready,
    input  logic [STAGES-1:0]              stall,
    input  logic [STAGES-1:0]              flush,
    output logic                           out_valid,
    output logic [WIDTH-1:0]               out_data,
    input  logic                           out_ready,
    output logic [STAGES-1:0]              stage_valid,
    output logic [STAGES*WIDTH-1:0]        stage_data,
    output logic [$clog2(STAGES+1)-1:0]    occupancy,
    output logic [CNTW-1:0]                flush_count
);

    localparam int OCCW = $clog2(STAGES+1);
    localparam int SUMW = CNTW + OCCW;
    localparam logic [SUMW-1:0] CNT_MAX = SUMW'({CNTW{1'b1}});

    logic [STAGES-1:0]             valid;
    logic [STAGES-1:0]             hold;
    logic [STAGES-1:0]             v_n;
    logic [STAGES-1:0][WIDTH-1:0]  data;
    logic [STAGES-1:0][WIDTH-1:0]  d_n;
    logic [OCCW-1:0]               occ_n;
    logic [OCCW-1:0]               flushed;
    logic [SUMW-1:0]               cnt_sum;

    // Hold propagates upstream through every stage, valid or not.
    always_comb begin
        hold = '0;
        hold[STAGES-1] = stall[STAGES-1] | (valid[STAGES-1] & ~out_ready);
        for (int i = STAGES - 2; i >= 0; i--) begin
            hold[i] = stall[i] | hold[i+1];
        end
    end

    always_comb begin
        v_n = valid;
        d_n = data;
        for (int i = 0; i < STAGES; i++) begin
            if (flush[i]) begin
                v_n[i] = 1'b0;
                d_n[i] = '0;
            end else if (hold[i]) begin
                v_n[i] = valid[i];
                d_n[i] = data[i];
            end else if (i == 0) begin
                v_n[i] = in_valid;
                d_n[i] = in_valid ? in_data : '0;
            end else if (hold[i-1]) begin
                v_n[i] = 1'b0;
                d_n[i] = '0;
            end else begin
                v_n[i] = valid[i-1];
                d_n[i] = data[i-1];
            end
        end
    end

    always_comb begin
        occ_n   = '0;
        flushed = '0;
        for (int i = 0; i < STAGES; i++) begin
            occ_n   = occ_n + OCCW'(v_n[i]);
            flushed = flushed + OCCW'(flush[i] & valid[i]);
        end
        cnt_sum = SUMW'(flush_count) + SUMW'(flushed);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid       <= '0;
            data        <= '0;
            occupancy   <= '0;
            flush_count <= '0;
        end else begin
            valid     <= v_n;
            data      <= d_n;
            occupancy <= occ_n;
            // Saturate rather than wrap so a long-running count stays meaningful.
            flush_count <= (cnt_sum > CNT_MAX) ? {CNTW{1'b1}} : cnt_sum[CNTW-1:0];
        end
    end

    assign in_ready    = ~hold[0];
    assign out_valid   = valid[STAGES-1];
    assign out_data    = data[STAGES-1];
    assign stage_valid = valid;
    assign stage_data  = data;

endmodule

// File: tb/tb_pipe_reg_chain.sv
// tb/tb_pipe_reg_chain.sv - directed self-checking bench for pipe_reg_chain
module tb_pipe_reg_chain;

    localparam int WIDTH  = 8;
    localparam int STAGES = 3;
    localparam int CNTW   = 2;

    logic                     clk = 1'b0;
    logic                     reset = 1'b1;
    logic                     in_valid = 1'b0;
    logic [WIDTH-1:0]         in_data = '0;
    logic                     in_ready;
    logic [STAGES-1:0]        stall = '0;
    logic [STAGES-1:0]        flush = '0;
    logic                     out_valid;
    logic [WIDTH-1:0]         out_data;
    logic                     out_ready = 1'b1;
    logic [STAGES-1:0]        stage_valid;
    logic [STAGES*WIDTH-1:0]  stage_data;
    logic [1:0]               occupancy;
    logic [CNTW-1:0]          flush_count;

    int n_cmp = 0;
    int n_bad = 0;

    int st_in  [6] = '{'h11, 'h22, 'h33, 0, 0, 0};
    int st_ov  [6] = '{0, 0, 1, 1, 1, 0};
    int st_out [6] = '{0, 0, 'h11, 'h22, 'h33, 0};
    int st_occ [6] = '{1, 2, 3, 2, 1, 0};
    int bp_out [3] = '{'hC2, 'hC3, 'hC4};

    pipe_reg_chain #(.WIDTH(WIDTH), .STAGES(STAGES), .CNTW(CNTW)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .stall(stall), .flush(flush), .out_valid(out_valid),
        .out_data(out_data), .out_ready(out_ready), .stage_valid(stage_valid),
        .stage_data(stage_data), .occupancy(occupancy), .flush_count(flush_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        stall = '0;
        flush = '0;
        in_valid = 1'b0;
        in_data = '0;
        out_ready = 1'b1;
        tick();
        reset = 1'b0;
    endtask

    task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic [7:0] c);
        in_valid = 1'b1;
        in_data = a;
        tick();
        in_data = b;
        tick();
        in_data = c;
        tick();
        in_valid = 1'b0;
        in_data = '0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        // reset state
        do_reset();
        check("rst_valid", 32'(stage_valid), 0);
        check("rst_data", 32'(stage_data), 0);
        check("rst_out", 32'({out_valid, out_data}), 0);
        check("rst_occ", 32'(occupancy), 0);
        check("rst_fcnt", 32'(flush_count), 0);

        // streaming 0x11,0x22,0x33
        for (int c = 0; c < 6; c++) begin
            in_valid = (c < 3);
            in_data  = 8'(st_in[c]);
            #1;
            check($sformatf("stream_ready%0d", c), 32'(in_ready), 1);
            tick();
            check($sformatf("stream_ov%0d", c), 32'(out_valid), 32'(st_ov[c]));
            check($sformatf("stream_od%0d", c), 32'(out_data), 32'(st_out[c]));
            check($sformatf("stream_occ%0d", c), 32'(occupancy), 32'(st_occ[c]));
        end

        // mid-stall bubble
        do_reset();
        fill(8'hA1, 8'hA2, 8'hA3);
        check("bub_full", 32'(stage_data), 'hA1A2A3);
        check("bub_out_a1", 32'(out_data), 'hA1);
        in_valid = 1'b1;
        in_data  = 8'hA4;
        stall    = 3'b010;
        #1;
        check("bub_ready", 32'(in_ready), 0);
        tick();
        stall = '0;
        check("bub_valid", 32'(stage_valid), 'b011);
        check("bub_data", 32'(stage_data), 'h00A2A3);
        tick();
        in_valid = 1'b0;
        check("bub_out_a2", 32'({out_valid, out_data}), 'h1A2);
        tick();
        check("bub_out_a3", 32'({out_valid, out_data}), 'h1A3);
        tick();
        check("bub_out_a4", 32'({out_valid, out_data}), 'h1A4);

        // flush with stall
        do_reset();
        fill(8'hB1, 8'hB2, 8'hB3);
        flush = 3'b010;
        stall = 3'b100;
        tick();
        flush = '0;
        stall = '0;
        check("fs_valid", 32'(stage_valid), 'b101);
        check("fs_data", 32'(stage_data), 'hB100B3);
        check("fs_fcnt", 32'(flush_count), 1);
        check("fs_occ", 32'(occupancy), 2);

        // backpressure
        do_reset();
        fill(8'hC1, 8'hC2, 8'hC3);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 8'hC4;
        for (int c = 0; c < 4; c++) begin
            #1;
            check($sformatf("bp_ready%0d", c), 32'(in_ready), 0);
            tick();
            check($sformatf("bp_hold%0d", c), 32'(stage_data), 'hC1C2C3);
        end
        out_ready = 1'b1;
        #1;
        check("bp_ready_rel", 32'(in_ready), 1);
        for (int c = 0; c < 3; c++) begin
            tick();
            in_valid = 1'b0;
            check($sformatf("bp_drain%0d", c), 32'({out_valid, out_data}), 32'h100 | 32'(bp_out[c]));
        end

        // flush counter saturation
        do_reset();
        fill(8'hD1, 8'hD2, 8'hD3);
        flush = 3'b111;
        tick();
        flush = '0;
        check("sat_first", 32'(flush_count), 3);
        check("sat_occ", 32'(occupancy), 0);
        fill(8'hD4, 8'hD5, 8'hD6);
        flush = 3'b111;
        tick();
        flush = '0;
        check("sat_second", 32'(flush_count), 3);

        // asynchronous reset mid-stream
        do_reset();
        fill(8'hE1, 8'hE2, 8'hE3);
        tick();
        check("ar_occ_pre", 32'(occupancy), 2);
        check("ar_out_pre", 32'(out_data), 'hE2);
        #3;
        reset = 1'b1;
        #1;
        check("ar_valid", 32'(stage_valid), 0);
        check("ar_occ", 32'(occupancy), 0);
        check("ar_out", 32'(out_data), 0);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
